// File: rtl/pipe_sched_if.sv
// Handshake bundle between the pipeline scheduler and the global control,
// layer stages and result-buffer writer.
interface pipe_sched_if #(
    parameter int STAGE_NUM = 5,
    parameter int IDX_W     = 4
);
    logic                 start_i;
    logic [STAGE_NUM-1:0] stage_done_i;
    logic                 buf_wr_done_i;
    logic [STAGE_NUM-1:0] stage_start_o;
    logic                 wr_start_o;
    logic [IDX_W-1:0]     img_idx_o;
    logic [IDX_W-1:0]     done_cnt_o;
    logic                 busy_o;
    logic                 err_o;
    logic                 done_intr_o;
    logic                 done_led_o;

    // master: start/done source side (control, stages, buffer)
    modport master (
        output start_i, stage_done_i, buf_wr_done_i,
        input  stage_start_o, wr_start_o, img_idx_o, done_cnt_o,
               busy_o, err_o, done_intr_o, done_led_o
    );

    // slave: the scheduler itself
    modport slave (
        input  start_i, stage_done_i, buf_wr_done_i,
        output stage_start_o, wr_start_o, img_idx_o, done_cnt_o,
               busy_o, err_o, done_intr_o, done_led_o
    );
endinterface

// File: rtl/pipe_sched.sv
// Occupancy-tracking scheduler: launches layer k when layer k-1 holds a
// finished image and layer k is idle, then hands results to the buffer writer.
module pipe_sched #(
    parameter int IN_IMG_NUM = 10,
    parameter int STAGE_NUM  = 5,
    parameter int IDX_W      = $clog2(IN_IMG_NUM + 1)
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    pipe_sched_if.slave  bus
);
    typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} glob_st_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL, S_DRAIN} stage_st_t;

    localparam int               LAST      = STAGE_NUM - 1;
    localparam logic [IDX_W-1:0] IMG_TOTAL = IDX_W'(IN_IMG_NUM);
    localparam logic [IDX_W-1:0] IMG_LAST  = IDX_W'(IN_IMG_NUM - 1);

    glob_st_t             g_q, g_d;
    logic                 start_q;
    logic [IDX_W-1:0]     img_idx_q, img_idx_d;
    logic [IDX_W-1:0]     done_cnt_q, done_cnt_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 intr_q, intr_d;
    logic                 led_q, led_d;
    logic [STAGE_NUM-1:0] stage_start_q, stage_start_d;
    logic                 wr_start_q, wr_start_d;

    logic                 run;
    logic                 start_edge;
    logic                 clear;
    logic [STAGE_NUM-1:0] launch;
    logic                 launch_wr;
    logic [STAGE_NUM-1:0] done_ok;
    logic                 wr_ok;
    logic [STAGE_NUM-1:0][1:0] st_vec;

    assign run        = (g_q == G_RUN);
    assign start_edge = bus.start_i & ~start_q;
    assign clear      = start_edge && (g_q != G_RUN);

    // Consumer of the last stage is the result-buffer writer.
    assign launch_wr = run && (st_vec[LAST] == S_FULL);
    assign wr_ok     = run && bus.buf_wr_done_i && (st_vec[LAST] == S_DRAIN);

    genvar gi;
    generate
        for (gi = 0; gi < STAGE_NUM; gi++) begin : g_stage
            stage_st_t st_q, st_d;
            logic      consume;
            logic      rel_ev;

            assign st_vec[gi]  = st_q;
            assign done_ok[gi] = run && bus.stage_done_i[gi] && (st_q == S_RUN);

            if (gi == 0) begin : g_first
                assign launch[gi] = run && (st_q == S_IDLE) && (img_idx_q < IMG_TOTAL);
            end else begin : g_follow
                assign launch[gi] = run && (st_q == S_IDLE) && (st_vec[gi-1] == S_FULL);
            end

            if (gi == LAST) begin : g_tail
                assign consume = launch_wr;
                assign rel_ev  = wr_ok;
            end else begin : g_body
                assign consume = launch[gi+1];
                assign rel_ev  = done_ok[gi+1];
            end

            always_comb begin
                st_d = st_q;
                if (clear) begin
                    st_d = S_IDLE;
                end else begin
                    case (st_q)
                        S_IDLE:  if (launch[gi]) st_d = S_RUN;
                        S_RUN:   if (done_ok[gi]) st_d = S_FULL;
                        S_FULL:  if (consume)    st_d = S_DRAIN;
                        S_DRAIN: if (rel_ev)     st_d = S_IDLE;
                        default: st_d = S_IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    st_q <= S_IDLE;
                end else begin
                    st_q <= st_d;
                end
            end
        end
    endgenerate

    always_comb begin
        g_d           = g_q;
        img_idx_d     = img_idx_q;
        done_cnt_d    = done_cnt_q;
        led_d         = led_q;
        intr_d        = 1'b0;
        stage_start_d = launch;
        wr_start_d    = launch_wr;
        // Any done pulse not matched to a stage in the right state is a protocol error.
        err_d = err_q | (|(bus.stage_done_i & ~done_ok)) | (bus.buf_wr_done_i & ~wr_ok);
        if (clear) begin
            g_d        = G_RUN;
            img_idx_d  = '0;
            done_cnt_d = '0;
            err_d      = 1'b0;
            led_d      = 1'b0;
        end else if (run) begin
            if (launch[0]) begin
                img_idx_d = img_idx_q + 1'b1;
            end
            if (wr_ok) begin
                done_cnt_d = done_cnt_q + 1'b1;
                if (done_cnt_q == IMG_LAST) begin
                    g_d    = G_DONE;
                    intr_d = 1'b1;
                    led_d  = 1'b1;
                end
            end
        end
        busy_d = (g_d == G_RUN);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            g_q           <= G_IDLE;
            start_q       <= 1'b0;
            img_idx_q     <= '0;
            done_cnt_q    <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            intr_q        <= 1'b0;
            led_q         <= 1'b0;
            stage_start_q <= '0;
            wr_start_q    <= 1'b0;
        end else begin
            g_q           <= g_d;
            start_q       <= bus.start_i;
            img_idx_q     <= img_idx_d;
            done_cnt_q    <= done_cnt_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            intr_q        <= intr_d;
            led_q         <= led_d;
            stage_start_q <= stage_start_d;
            wr_start_q    <= wr_start_d;
        end
    end

    assign bus.stage_start_o = stage_start_q;
    assign bus.wr_start_o    = wr_start_q;
    assign bus.img_idx_o     = img_idx_q;
    assign bus.done_cnt_o    = done_cnt_q;
    assign bus.busy_o        = busy_q;
    assign bus.err_o         = err_q;
    assign bus.done_intr_o   = intr_q;
    assign bus.done_led_o    = led_q;
endmodule
